ball_mover: RTL and testbench
=============================

BALL_MOVER -- requirements
Module: ball_mover

Interface
REQ-001 Parameter X_MAX, default 8'd148, largest legal ball_x value.
REQ-002 Parameter Y_MAX, default 8'd108, largest legal ball_y value.
REQ-003 clk  input  1  system clock, 50 MHz; the block's only clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 chipselect  input  1  Avalon-MM slave select.
REQ-006 write  input  1  Avalon-MM write strobe; qualified by chipselect.
REQ-007 address  input  3  register index.
REQ-008 writedata  input  8  write data.
REQ-009 vga_vs  input  1  active-low vertical sync from the VGA counters, same clock domain.
REQ-010 ball_x  output  8  ball X position, in 4-pixel units, for the display stage.
REQ-011 ball_y  output  8  ball Y position, in 4-pixel units, for the display stage.
REQ-012 update_strobe  output  1  one-cycle pulse on the cycle ball_x/ball_y take a motion-computed value.

Function
REQ-013 The block SHALL decode a register write when chipselect && write, at address 0: ctrl {bit0 enable, bit1 dir_x (1=+), bit2 dir_y (1=+)}; 1: speed_x[3:0]; 2: speed_y[3:0]; 3: frame_div; 4: set X; 5: set Y; addresses 6-7 ignored.
REQ-014 The block SHALL register vga_vs every cycle and detect frame start as prev_vs==1 && vga_vs==0.
REQ-015 On a frame start with enable==1, the block SHALL compare frame_cnt to frame_div: if equal, clear frame_cnt and start an update; otherwise increment frame_cnt (8-bit) and not update.
REQ-016 On a frame start with enable==0, frame_cnt SHALL hold.
REQ-017 FSM states SHALL be IDLE, UPD_X, UPD_Y, COMMIT: IDLE->UPD_X on update start; UPD_X->UPD_Y->COMMIT->IDLE unconditionally, one cycle each.
REQ-018 On entry to UPD_X, speed_x and speed_y SHALL be latched into shadow registers; later speed writes take effect at the next update.
REQ-019 UPD_X SHALL compute in 9-bit unsigned arithmetic: if dir_x=1 and x+sx >= X_MAX, then next_x=X_MAX and dir_x<=0; if dir_x=0 and x <= sx, then next_x=0 and dir_x<=1; otherwise next_x=x±sx.
REQ-020 UPD_Y SHALL apply the identical rule using y, sy, dir_y and Y_MAX.
REQ-021 In COMMIT, ball_x and ball_y SHALL load next_x and next_y on the same edge, and update_strobe SHALL be 1 for exactly that cycle.
REQ-022 Latency: ball_x/ball_y SHALL change exactly 3 clk edges after the edge on which the frame start is detected.
REQ-023 Speed 0 on an axis SHALL leave that axis unchanged and SHALL NOT flip its direction, unless the position already equals the limit in the travel direction.
REQ-024 A write to address 4 or 5 SHALL load ball_x or ball_y (clamped to X_MAX or Y_MAX) on the next edge, SHALL force the FSM to IDLE with no strobe, and SHALL discard any in-flight update.
REQ-025 A write to address 0 during UPD_X, UPD_Y or COMMIT SHALL update enable immediately, SHALL let the current update complete, and SHALL have its dir bits overwritten by any bounce computed in that update.
REQ-026 A frame start detected while not in IDLE SHALL be ignored and SHALL NOT advance frame_cnt.
REQ-027 ball_x and ball_y SHALL change only in COMMIT, on a set-X/set-Y write, or on reset.

Reset
REQ-028 On reset assertion, asynchronously: ball_x=3, ball_y=3, update_strobe=0, state=IDLE, enable=0, dir_x=1, dir_y=1, speed_x=1, speed_y=1, frame_div=0, frame_cnt=0, prev_vs=1.
REQ-029 Reset asserted mid-update SHALL abort the update with no strobe; after release, the block SHALL wait for a fresh frame start.

Verification
REQ-030 Reset, write ctrl=0x07, drive one vga_vs falling edge -> ball_x=4, ball_y=4, one update_strobe pulse, 3 cycles after detection.
REQ-031 Set X=146, speed_x=3, dir_x=1, one frame -> ball_x=148, dir_x=0; next frame -> ball_x=145.
REQ-032 Set Y=2, speed_y=5, dir_y=0, one frame -> ball_y=0, dir_y=1; next frame -> ball_y=5.
REQ-033 frame_div=2, enable=1, 6 frame starts -> exactly 2 strobes, on the 3rd and 6th frames.
REQ-034 Write set X=200 during UPD_Y -> ball_x=148, no strobe that frame, ball_y unchanged.
REQ-035 Assert reset during UPD_X -> all outputs at reset values immediately; no strobe until enable is set and a new frame start occurs.

Source files
------------

// File: rtl/ball_mover.sv
// Moves a ball on a frame-divided schedule, bouncing off the screen edges.
// Registers are written over Avalon-MM. Each update walks IDLE->UPD_X->UPD_Y->COMMIT.
module ball_mover #(
    parameter logic [7:0] X_MAX = 8'd148,
    parameter logic [7:0] Y_MAX = 8'd108
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       chipselect,
    input  logic       write,
    input  logic [2:0] address,
    input  logic [7:0] writedata,
    input  logic       vga_vs,
    output logic [7:0] ball_x,
    output logic [7:0] ball_y,
    output logic       update_strobe
);

    typedef enum logic [1:0] {IDLE, UPD_X, UPD_Y, COMMIT} state_t;
    typedef struct packed {
        logic       dir;
        logic [7:0] pos;
    } axis_t;

    state_t     state, next_state;
    logic       enable, dir_x, dir_y, prev_vs;
    logic [3:0] speed_x, speed_y, sx_sh, sy_sh;
    logic [7:0] frame_div, frame_cnt;
    logic [7:0] next_x, next_y;
    logic       bounce_x, bounce_y, bdir_x, bdir_y;
    logic       wr, wr_ctrl, set_x_wr, set_y_wr, set_wr;
    logic       frame_start, frame_go, upd_start;
    logic       ld_x, ld_y, commit;
    axis_t      ax, ay;

    // Bounce rule in 9-bit arithmetic so x+sx cannot wrap past the limit.
    function automatic axis_t step_axis(input logic [7:0] pos, input logic [3:0] spd,
                                        input logic dir, input logic [7:0] lim);
        axis_t      r;
        logic [8:0] sum;
        sum = {1'b0, pos} + {5'b0, spd};
        if (dir) begin
            if (sum >= {1'b0, lim}) r = '{dir: 1'b0, pos: lim};
            else                    r = '{dir: 1'b1, pos: sum[7:0]};
        end else begin
            if (pos <= {4'b0, spd}) r = '{dir: 1'b1, pos: 8'd0};
            else                    r = '{dir: 1'b0, pos: pos - {4'b0, spd}};
        end
        return r;
    endfunction

    always_comb begin
        wr          = chipselect & write;
        wr_ctrl     = wr && (address == 3'd0);
        set_x_wr    = wr && (address == 3'd4);
        set_y_wr    = wr && (address == 3'd5);
        set_wr      = set_x_wr | set_y_wr;
        frame_start = prev_vs & ~vga_vs;
        frame_go    = frame_start & enable & (state == IDLE);
        upd_start   = frame_go && (frame_cnt == frame_div) && !set_wr;
        ax          = step_axis(ball_x, sx_sh, dir_x, X_MAX);
        ay          = step_axis(ball_y, sy_sh, dir_y, Y_MAX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (set_wr) next_state = IDLE;
        else begin
            case (state)
                IDLE:    if (upd_start) next_state = UPD_X;
                UPD_X:   next_state = UPD_Y;
                UPD_Y:   next_state = COMMIT;
                COMMIT:  next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        ld_x   = (state == UPD_X);
        ld_y   = (state == UPD_Y);
        commit = (state == COMMIT) && !set_wr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_vs   <= 1'b1;
            frame_cnt <= 8'd0;
        end else begin
            prev_vs <= vga_vs;
            if (frame_go) frame_cnt <= (frame_cnt == frame_div) ? 8'd0 : frame_cnt + 8'd1;
        end
    end

    // A bounce computed by the running update wins over a ctrl write made during it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable    <= 1'b0;
            dir_x     <= 1'b1;
            dir_y     <= 1'b1;
            speed_x   <= 4'd1;
            speed_y   <= 4'd1;
            frame_div <= 8'd0;
        end else begin
            if (wr_ctrl) begin
                enable <= writedata[0];
                dir_x  <= writedata[1];
                dir_y  <= writedata[2];
            end
            if (commit && bounce_x) dir_x <= bdir_x;
            if (commit && bounce_y) dir_y <= bdir_y;
            if (wr && address == 3'd1) speed_x   <= writedata[3:0];
            if (wr && address == 3'd2) speed_y   <= writedata[3:0];
            if (wr && address == 3'd3) frame_div <= writedata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sx_sh    <= 4'd0;
            sy_sh    <= 4'd0;
            next_x   <= 8'd0;
            next_y   <= 8'd0;
            bounce_x <= 1'b0;
            bounce_y <= 1'b0;
            bdir_x   <= 1'b0;
            bdir_y   <= 1'b0;
        end else begin
            if (upd_start) begin
                sx_sh <= speed_x;
                sy_sh <= speed_y;
            end
            if (ld_x) begin
                next_x   <= ax.pos;
                bounce_x <= (ax.dir != dir_x);
                bdir_x   <= ax.dir;
            end
            if (ld_y) begin
                next_y   <= ay.pos;
                bounce_y <= (ay.dir != dir_y);
                bdir_y   <= ay.dir;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ball_x        <= 8'd3;
            ball_y        <= 8'd3;
            update_strobe <= 1'b0;
        end else begin
            update_strobe <= commit;
            if (set_x_wr)    ball_x <= (writedata > X_MAX) ? X_MAX : writedata;
            else if (commit) ball_x <= next_x;
            if (set_y_wr)    ball_y <= (writedata > Y_MAX) ? Y_MAX : writedata;
            else if (commit) ball_y <= next_y;
        end
    end

endmodule

// File: tb/tb_ball_mover.sv
// Self-checking bench for ball_mover: vector table, corner-case sequences,
// and a randomized run against a frame-level reference model.
module tb_ball_mover;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       chipselect = 1'b0, write = 1'b0, vga_vs = 1'b1;
    logic [2:0] address = 3'd0;
    logic [7:0] writedata = 8'd0;
    logic [7:0] ball_x, ball_y;
    logic       update_strobe;

    int n_checks = 0, n_fail = 0, strobe_cnt = 0;
    bit model_on = 0;

    // reference model state
    int m_x, m_y, m_sx, m_sy, m_div, m_cnt, m_cd, m_px, m_py;
    bit m_en, m_dx, m_dy, m_pvs, m_pdx, m_pdy, m_strobe;

    ball_mover dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
        .address(address), .writedata(writedata), .vga_vs(vga_vs),
        .ball_x(ball_x), .ball_y(ball_y), .update_strobe(update_strobe)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void bounce(input int p, input int s, input int lim, input bit d,
                                   output int np, output bit nd);
        if (d) begin
            if (p + s >= lim) begin np = lim; nd = 0; end
            else              begin np = p + s; nd = 1; end
        end else begin
            if (p <= s) begin np = 0; nd = 1; end
            else        begin np = p - s; nd = 0; end
        end
    endfunction

    task automatic model_init();
        m_x = 3; m_y = 3; m_dx = 1; m_dy = 1; m_en = 0; m_sx = 1; m_sy = 1;
        m_div = 0; m_cnt = 0; m_pvs = 1; m_cd = 0; m_strobe = 0;
    endtask

    // One clock edge of the model; inputs are those held before the edge.
    task automatic model_step();
        bit wr_m, set_m, fs, busy;
        if (reset) begin model_init(); return; end
        wr_m  = chipselect && write;
        set_m = wr_m && (address == 3'd4 || address == 3'd5);
        fs    = m_pvs && !vga_vs;
        m_pvs = vga_vs;
        busy  = (m_cd != 0);
        m_strobe = 0;
        if (set_m) m_cd = 0;
        else if (m_cd != 0) begin
            m_cd--;
            if (m_cd == 0) begin
                m_x = m_px; m_y = m_py; m_dx = m_pdx; m_dy = m_pdy; m_strobe = 1;
            end
        end
        if (fs && !busy && m_en) begin
            if (m_cnt == m_div) begin
                m_cnt = 0;
                if (!set_m) begin
                    bounce(m_x, m_sx, 148, m_dx, m_px, m_pdx);
                    bounce(m_y, m_sy, 108, m_dy, m_py, m_pdy);
                    m_cd = 3;
                end
            end else m_cnt = (m_cnt + 1) % 256;
        end
        if (wr_m) begin
            case (address)
                3'd0: begin m_en = writedata[0]; m_dx = writedata[1]; m_dy = writedata[2]; end
                3'd1: m_sx = int'(writedata[3:0]);
                3'd2: m_sy = int'(writedata[3:0]);
                3'd3: m_div = int'(writedata);
                3'd4: m_x = (writedata > 8'd148) ? 148 : int'(writedata);
                3'd5: m_y = (writedata > 8'd108) ? 108 : int'(writedata);
                default: ;
            endcase
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (model_on) model_step();
        #1;
        if (update_strobe) strobe_cnt++;
        if (model_on) begin
            check("rand_x", int'(ball_x), m_x);
            check("rand_y", int'(ball_y), m_y);
            check("rand_strobe", int'(update_strobe), int'(m_strobe));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; vga_vs = 1'b1; chipselect = 1'b0; write = 1'b0;
        cycle(); cycle();
        reset = 1'b0;
    endtask

    task automatic reg_wr(input logic [2:0] a, input logic [7:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        cycle();
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic frame_pulse();
        vga_vs = 1'b0;
        cycle();
        vga_vs = 1'b1;
        repeat (5) cycle();
    endtask

    typedef struct {
        logic [7:0] ctrl, sx, sy, set_x, set_y;
        int ex1, ey1, ex2, ey2;
    } vec_t;

    vec_t tbl[6];
    int   exp_bx[5] = '{3, 3, 3, 4, 4};
    int   exp_st[5] = '{0, 0, 0, 1, 0};

    initial begin
        tbl[0] = '{8'h07, 8'd1,  8'd1,  8'd3,   8'd3,   4,   4,   5,   5};
        tbl[1] = '{8'h03, 8'd3,  8'd0,  8'd146, 8'd50,  148, 50,  145, 50};
        tbl[2] = '{8'h01, 8'd0,  8'd5,  8'd20,  8'd2,   20,  0,   20,  5};
        tbl[3] = '{8'h07, 8'd0,  8'd0,  8'd200, 8'd108, 148, 108, 148, 108};
        tbl[4] = '{8'h01, 8'd15, 8'd15, 8'd0,   8'd0,   0,   0,   15,  15};
        tbl[5] = '{8'h05, 8'd7,  8'd9,  8'd100, 8'd100, 93,  108, 86,  99};

        // reset state
        do_reset();
        check("reset_x", int'(ball_x), 3);
        check("reset_y", int'(ball_y), 3);
        check("reset_strobe", int'(update_strobe), 0);

        // first update and its latency after frame-start detection
        reg_wr(3'd0, 8'h07);
        vga_vs = 1'b0;
        for (int e = 0; e < 5; e++) begin
            cycle();
            vga_vs = 1'b1;
            check($sformatf("lat_x_e%0d", e), int'(ball_x), exp_bx[e]);
            check($sformatf("lat_y_e%0d", e), int'(ball_y), exp_bx[e]);
            check($sformatf("lat_strobe_e%0d", e), int'(update_strobe), exp_st[e]);
        end

        // vector table: two frames per record
        for (int i = 0; i < 6; i++) begin
            do_reset();
            reg_wr(3'd1, tbl[i].sx);
            reg_wr(3'd2, tbl[i].sy);
            reg_wr(3'd4, tbl[i].set_x);
            reg_wr(3'd5, tbl[i].set_y);
            reg_wr(3'd0, tbl[i].ctrl);
            strobe_cnt = 0;
            frame_pulse();
            check($sformatf("vec%0d_x1", i), int'(ball_x), tbl[i].ex1);
            check($sformatf("vec%0d_y1", i), int'(ball_y), tbl[i].ey1);
            check($sformatf("vec%0d_st1", i), strobe_cnt, 1);
            strobe_cnt = 0;
            frame_pulse();
            check($sformatf("vec%0d_x2", i), int'(ball_x), tbl[i].ex2);
            check($sformatf("vec%0d_y2", i), int'(ball_y), tbl[i].ey2);
            check($sformatf("vec%0d_st2", i), strobe_cnt, 1);
        end

        // frame divider: strobes only on frames 3 and 6
        do_reset();
        reg_wr(3'd3, 8'd2);
        reg_wr(3'd0, 8'h07);
        for (int f = 1; f <= 6; f++) begin
            strobe_cnt = 0;
            frame_pulse();
            check($sformatf("div_frame%0d", f), strobe_cnt, (f == 3 || f == 6) ? 1 : 0);
        end

        // set X during UPD_Y discards the update
        do_reset();
        reg_wr(3'd0, 8'h07);
        strobe_cnt = 0;
        vga_vs = 1'b0; cycle();
        vga_vs = 1'b1; cycle();
        chipselect = 1'b1; write = 1'b1; address = 3'd4; writedata = 8'd200;
        cycle();
        chipselect = 1'b0; write = 1'b0;
        check("setx_mid_x", int'(ball_x), 148);
        repeat (5) cycle();
        check("setx_mid_strobe", strobe_cnt, 0);
        check("setx_mid_y", int'(ball_y), 3);
        check("setx_mid_x_hold", int'(ball_x), 148);

        // reset asserted during UPD_X
        do_reset();
        reg_wr(3'd4, 8'd50);
        reg_wr(3'd0, 8'h07);
        vga_vs = 1'b0; cycle();
        vga_vs = 1'b1; reset = 1'b1;
        #1;
        check("rst_mid_x", int'(ball_x), 3);
        check("rst_mid_y", int'(ball_y), 3);
        check("rst_mid_strobe", int'(update_strobe), 0);
        cycle();
        reset = 1'b0;
        strobe_cnt = 0;
        repeat (4) cycle();
        frame_pulse();
        check("rst_after_disabled_strobe", strobe_cnt, 0);
        check("rst_after_disabled_x", int'(ball_x), 3);
        reg_wr(3'd0, 8'h07);
        frame_pulse();
        check("rst_after_enabled_strobe", strobe_cnt, 1);
        check("rst_after_enabled_x", int'(ball_x), 4);

        // disabling mid-update lets that update finish
        do_reset();
        reg_wr(3'd0, 8'h07);
        strobe_cnt = 0;
        vga_vs = 1'b0; cycle();
        vga_vs = 1'b1; cycle();
        reg_wr(3'd0, 8'h00);
        repeat (4) cycle();
        check("ctrl_mid_strobe", strobe_cnt, 1);
        check("ctrl_mid_x", int'(ball_x), 4);
        frame_pulse();
        check("ctrl_mid_next_strobe", strobe_cnt, 1);

        // frame start while busy is ignored and does not advance frame_cnt
        do_reset();
        reg_wr(3'd3, 8'd1);
        reg_wr(3'd0, 8'h07);
        strobe_cnt = 0;
        frame_pulse();
        check("busy_f1", strobe_cnt, 0);
        vga_vs = 1'b0; cycle();
        vga_vs = 1'b1; cycle();
        vga_vs = 1'b0; cycle();
        vga_vs = 1'b1; repeat (5) cycle();
        check("busy_f2", strobe_cnt, 1);
        frame_pulse();
        check("busy_f3", strobe_cnt, 1);
        frame_pulse();
        check("busy_f4", strobe_cnt, 2);

        // randomized run against the reference model
        model_on = 1;
        do_reset();
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                frame_pulse();
            end else begin
                logic [2:0] a;
                logic [7:0] d;
                a = 3'($urandom_range(0, 7));
                d = 8'($urandom);
                if (a == 3'd0) d[0] = ($urandom_range(0, 3) != 0);
                if (a == 3'd3) d = 8'($urandom_range(0, 2));
                chipselect = ($urandom_range(0, 9) != 0);
                write = 1'b1; address = a; writedata = d;
                cycle();
                chipselect = 1'b0; write = 1'b0;
                repeat (5) cycle();
            end
        end
        model_on = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
